// File: rtl/fms_pkg.sv
// Shared constants and helpers for the phase sequencer slice.
package fms_pkg;

  // Default parameter values used by the sequencer, its interface and the timer.
  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_IN_PHASE   = 1;
  localparam int DEF_OUT_PHASE  = 3;
  localparam int DEF_HOLD_W     = 4;
  localparam int DEF_CNT_W      = 8;

  // Phase 0 is the idle phase; every other phase belongs to a sweep.
  localparam int PHASE_IDLE = 0;

  // Width of the phase number for a given phase count (never below one bit).
  function automatic int phase_w(input int num_phases);
    return (num_phases <= 2) ? 1 : $clog2(num_phases);
  endfunction

endpackage : fms_pkg

// File: rtl/fms_sequencer_if.sv
// Control/status bundle of the phase sequencer.
// The master side requests sweeps; the slave side (the sequencer) reports phase state.
interface fms_sequencer_if
  import fms_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int HOLD_W     = DEF_HOLD_W,
  parameter int CNT_W      = DEF_CNT_W
);

  localparam int PW = phase_w(NUM_PHASES);

  logic              act;
  logic              stop;
  logic              single;
  logic [HOLD_W-1:0] hold;
  logic              EN_in;
  logic              EN_out;
  logic [PW-1:0]     Est;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sweeps;

  modport master (
    output act, stop, single, hold,
    input  EN_in, EN_out, Est, busy, done, sweeps
  );

  modport slave (
    input  act, stop, single, hold,
    output EN_in, EN_out, Est, busy, done, sweeps
  );

endinterface : fms_sequencer_if

// File: rtl/fms_dwell_timer.sv
// Dwell timer: loads a count, counts down to zero and flags expiry while enabled.
// A loaded value of N keeps expire low for N cycles, so the phase lasts N+1 cycles.
module fms_dwell_timer
  import fms_pkg::*;
#(
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              en,
  output logic              expire
);

  logic [HOLD_W-1:0] cnt_q;

  // Count register: a load wins over counting, and the count parks at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule : fms_dwell_timer

// File: rtl/fms_sequencer.sv
// Phase sequencer: steps through phases 1..NUM_PHASES-1 with a programmable
// dwell per phase, in single-sweep or continuous mode, with a deferred stop.
module fms_sequencer
  import fms_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int IN_PHASE   = DEF_IN_PHASE,
  parameter int OUT_PHASE  = DEF_OUT_PHASE,
  parameter int HOLD_W     = DEF_HOLD_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst,
  fms_sequencer_if.slave bus
);

  localparam int PW = phase_w(NUM_PHASES);

  // Parameter legality is enforced while elaborating.
  if (NUM_PHASES < 3 || NUM_PHASES > 16) begin : g_bad_num_phases
    $error("fms_sequencer: NUM_PHASES=%0d outside 3..16", NUM_PHASES);
  end
  if (IN_PHASE < 1 || IN_PHASE > NUM_PHASES - 1) begin : g_bad_in_phase
    $error("fms_sequencer: IN_PHASE=%0d outside 1..%0d", IN_PHASE, NUM_PHASES - 1);
  end
  if (OUT_PHASE < 1 || OUT_PHASE > NUM_PHASES - 1) begin : g_bad_out_phase
    $error("fms_sequencer: OUT_PHASE=%0d outside 1..%0d", OUT_PHASE, NUM_PHASES - 1);
  end
  if (OUT_PHASE == IN_PHASE) begin : g_bad_phase_pair
    $error("fms_sequencer: OUT_PHASE must differ from IN_PHASE (%0d)", IN_PHASE);
  end

  // Registered state.
  logic [PW-1:0]     state_q,  state_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic              single_q, single_d;
  logic              pend_q,   pend_d;
  logic [CNT_W-1:0]  sweeps_q, sweeps_d;
  logic              done_q,   done_d;
  logic              first_q,  first_d;

  // Dwell timer handshake.
  logic              tmr_load;
  logic [HOLD_W-1:0] tmr_val;
  logic              tmr_expire;
  logic              is_busy;

  assign is_busy = (state_q != PW'(PHASE_IDLE));

  fms_dwell_timer #(
    .HOLD_W (HOLD_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (is_busy),
    .expire   (tmr_expire)
  );

  // State register: phase, latched settings, pending stop, counters and flags.
  // NOTE: all registers are cleared on reset, including the latched settings,
  // so an aborted sweep leaves nothing behind that could leak into the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= PW'(PHASE_IDLE);
      hold_q   <= '0;
      single_q <= 1'b0;
      pend_q   <= 1'b0;
      sweeps_q <= '0;
      done_q   <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q  <= state_d;
      hold_q   <= hold_d;
      single_q <= single_d;
      pend_q   <= pend_d;
      sweeps_q <= sweeps_d;
      done_q   <= done_d;
      first_q  <= first_d;
    end
  end

  // Next-state logic: start, dwell-driven advance, sweep wrap or return to idle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d  = state_q;
    hold_d   = hold_q;
    single_d = single_q;
    pend_d   = pend_q;
    sweeps_d = sweeps_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = hold_q;

    if (int'(state_q) >= NUM_PHASES) begin
      // Unreachable encoding: recover to idle without counting or signalling.
      state_d = PW'(PHASE_IDLE);
      pend_d  = 1'b0;
    end else if (!is_busy) begin
      // Idle: act starts a sweep and latches hold/single; stop alone is ignored.
      if (bus.act) begin
        state_d  = PW'(1);
        hold_d   = bus.hold;
        single_d = bus.single;
        pend_d   = bus.stop;
        tmr_load = 1'b1;
        tmr_val  = bus.hold;
      end
    end else begin
      if (bus.stop) begin
        pend_d = 1'b1;
      end
      if (tmr_expire) begin
        if (int'(state_q) == NUM_PHASES - 1) begin
          sweeps_d = sweeps_q + 1'b1;
          if (single_q || pend_q || bus.stop) begin
            state_d = PW'(PHASE_IDLE);
            pend_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Continuous mode: start the next sweep with a freshly latched hold.
            state_d  = PW'(1);
            hold_d   = bus.hold;
            tmr_load = 1'b1;
            tmr_val  = bus.hold;
          end
        end else begin
          state_d  = state_q + 1'b1;
          tmr_load = 1'b1;
        end
      end
    end

    // Marks the first cycle of any newly entered active phase.
    first_d = (state_d != state_q) && (state_d != PW'(PHASE_IDLE));
  end

  // Output decode: Moore outputs from registered state only.
  always_comb begin
    bus.Est    = state_q;
    bus.busy   = is_busy;
    bus.EN_in  = first_q && (int'(state_q) == IN_PHASE);
    bus.EN_out = first_q && (int'(state_q) == OUT_PHASE);
    bus.done   = done_q;
    bus.sweeps = sweeps_q;
  end

endmodule : fms_sequencer

// File: tb/tb_fms_sequencer.sv
// Scoreboard bench for fms_sequencer: expected per-cycle outputs are queued when
// a sweep request is driven and compared as the sequencer produces them.
// A second instance with a 2-bit sweep counter runs on the same stimulus.
module tb_fms_sequencer;
  import fms_pkg::*;

  localparam int NP    = 4;
  localparam int IN_P  = 1;
  localparam int OUT_P = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       act = 1'b0;
  logic       stop = 1'b0;
  logic       single = 1'b0;
  logic [3:0] hold = '0;

  fms_sequencer_if #(.NUM_PHASES(NP), .HOLD_W(4), .CNT_W(8)) bus_a ();
  fms_sequencer_if #(.NUM_PHASES(NP), .HOLD_W(4), .CNT_W(2)) bus_b ();

  assign bus_a.act = act;
  assign bus_a.stop = stop;
  assign bus_a.single = single;
  assign bus_a.hold = hold;
  assign bus_b.act = act;
  assign bus_b.stop = stop;
  assign bus_b.single = single;
  assign bus_b.hold = hold;

  fms_sequencer #(.NUM_PHASES(NP), .IN_PHASE(IN_P), .OUT_PHASE(OUT_P), .HOLD_W(4), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fms_sequencer #(.NUM_PHASES(NP), .IN_PHASE(IN_P), .OUT_PHASE(OUT_P), .HOLD_W(4), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int est;
    bit en_in;
    bit en_out;
    bit busy;
    bit done;
    int sw;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sweeps_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Checks the idle/reset-like output state of both instances.
  task automatic check_idle(input string tag, input bit exp_done, input int exp_sw);
    check({tag, ".Est"},    32'(bus_a.Est), 32'd0);
    check({tag, ".busy"},   32'(bus_a.busy), 32'd0);
    check({tag, ".EN_in"},  32'(bus_a.EN_in), 32'd0);
    check({tag, ".EN_out"}, 32'(bus_a.EN_out), 32'd0);
    check({tag, ".done"},   32'(bus_a.done), 32'(exp_done));
    check({tag, ".sweeps"}, 32'(bus_a.sweeps), 32'(exp_sw % 256));
    check({tag, ".b_sweeps"}, 32'(bus_b.sweeps), 32'(exp_sw % 4));
  endtask

  // Queues the expected trace of n sweeps (first with hold h, later ones with h2),
  // drives the request, then pops and compares one entry per cycle.
  // stop_sweep selects the sweep whose phase 2 gets a one-cycle stop (-1: none).
  task automatic run_sweeps(input string name, input int h, input int h2, input bit sgl,
                            input bit stop_with_act, input int n, input int stop_sweep);
    exp_t e;
    int   hh;
    int   idx = 0;
    int   stop_at = -1;
    for (int s = 0; s < n; s++) begin
      hh = (s == 0) ? h : h2;
      for (int p = 1; p < NP; p++) begin
        for (int c = 0; c <= hh; c++) begin
          e.est    = p;
          e.en_in  = (p == IN_P) && (c == 0);
          e.en_out = (p == OUT_P) && (c == 0);
          e.busy   = 1'b1;
          e.done   = 1'b0;
          e.sw     = sweeps_done + s;
          if (s == stop_sweep && p == 2 && c == 0) stop_at = idx;
          sb.push_back(e);
          idx++;
        end
      end
    end
    e = '{est: 0, en_in: 1'b0, en_out: 1'b0, busy: 1'b0, done: 1'b1, sw: sweeps_done + n};
    sb.push_back(e);
    e.done = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    sweeps_done += n;

    act    = 1'b1;
    single = sgl;
    hold   = 4'(h);
    stop   = stop_with_act;
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s[%0d].Est", name, i),    32'(bus_a.Est),    32'(e.est));
      check($sformatf("%s[%0d].EN_in", name, i),  32'(bus_a.EN_in),  32'(e.en_in));
      check($sformatf("%s[%0d].EN_out", name, i), 32'(bus_a.EN_out), 32'(e.en_out));
      check($sformatf("%s[%0d].busy", name, i),   32'(bus_a.busy),   32'(e.busy));
      check($sformatf("%s[%0d].done", name, i),   32'(bus_a.done),   32'(e.done));
      check($sformatf("%s[%0d].sweeps", name, i), 32'(bus_a.sweeps), 32'(e.sw % 256));
      check($sformatf("%s[%0d].b_sweeps", name, i), 32'(bus_b.sweeps), 32'(e.sw % 4));
      check($sformatf("%s[%0d].b_done", name, i), 32'(bus_b.done),   32'(e.done));
      // act while busy must be ignored; hold changes only matter at a re-latch.
      act  = (i == 0);
      stop = (i == stop_at);
      hold = 4'(h2);
    end
    act  = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_idle("reset", 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);

    // Stop while idle is ignored.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("idle_stop", 1'b0, 0);
    @(negedge clk);
    check_idle("idle_stop2", 1'b0, 0);

    // Continuous, hold=0; stop in phase 2 of the third sweep ends after phase 3.
    run_sweeps("cont_h0", 0, 0, 1'b0, 1'b0, 3, 2);
    // Continuous; hold changed mid-sweep takes effect at the wrap only.
    run_sweeps("relatch", 1, 3, 1'b0, 1'b0, 2, 1);
    // Single sweep with hold=2: done on the tenth cycle after act.
    run_sweeps("single_h2", 2, 2, 1'b1, 1'b0, 1, -1);
    // act and stop together: exactly one sweep.
    run_sweeps("act_stop", 0, 0, 1'b0, 1'b1, 1, -1);

    // Reset during phase 2 aborts without done or count.
    act = 1'b1;
    single = 1'b0;
    hold = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      act = 1'b0;
    end
    check("abort.pre_Est", 32'(bus_a.Est), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort.reset", 1'b0, 0);
    rst = 1'b1;
    sweeps_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("abort.after[%0d]", i), 1'b0, 0);
    end

    // Five continuous sweeps after reset: the 2-bit counter wraps 1,2,3,0,1.
    run_sweeps("wrap5", 0, 0, 1'b0, 1'b0, 5, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fms_sequencer
